// File: rtl/lcd_time_display.sv
// ============================================================================
// lcd_time_display
//
// Shows the watch core's binary time as "HH:MM:SS" on an HD44780-compatible
// character LCD driven in 4-bit mode. After reset it waits for the panel to
// power up, runs the 4-bit initialisation sequence and the configuration
// commands, then keeps refreshing one frame after another: snapshot the time,
// set the DDRAM address, write the characters, pulse frame_done.
//
// Every nibble goes through the same engine: load SF_D/LCD_RS, hold two setup
// cycles, raise LCD_E for T_EPULSE cycles, drop it, then wait the gap that
// belongs to that nibble. SF_D and LCD_RS only change when the next nibble is
// loaded, so they are held through the whole gap.
//
// Optional feature (macro TWELVE_HOUR_EN): hours are shown in 12-hour form and
// each frame gets " AM" or " PM" appended (11 characters instead of 8).
//
// Ports:
//   CLK          in   system clock (50 MHz)
//   RST_N        in   asynchronous active-low reset
//   sec_digits   in   [5:0] seconds (0..59, not clamped)
//   min_digits   in   [5:0] minutes (0..59, not clamped)
//   hrs_digits   in   [4:0] hours   (0..23, not clamped)
//   SF_D         out  [3:0] LCD data nibble (board pins SF_D[11:8])
//   LCD_E        out  LCD enable strobe
//   LCD_RS       out  register select, 0 = command, 1 = data
//   LCD_RW       out  read/write select, tied to write
//   SF_CE0       out  StrataFlash chip enable, held inactive (1)
//   init_done    out  high once LCD initialisation has completed
//   frame_done   out  one-cycle pulse after the last character of a frame
// ============================================================================
module lcd_time_display #(
    parameter int T_POWERUP = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_EPULSE  = 12,
    parameter int T_NIBBLE  = 50,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int COL       = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [5:0] sec_digits,
    input  logic [5:0] min_digits,
    input  logic [4:0] hrs_digits,
    output logic [3:0] SF_D,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       SF_CE0,
    output logic       init_done,
    output logic       frame_done
);

`ifdef TWELVE_HOUR_EN
    localparam int NCHARS = 11;
`else
    localparam int NCHARS = 8;
`endif

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        CFG,
        SNAP,
        ADDR,
        CHARS,
        FRAME_END
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } phase_t;

    state_t      state_reg;
    phase_t      phase_reg;
    logic [3:0]  idx_reg;       // item index inside the current state
    logic        low_nib_reg;   // 0: high nibble of the byte, 1: low nibble
    logic [31:0] cnt_reg;
    logic [5:0]  sec_snap_reg;
    logic [5:0]  min_snap_reg;
    logic [4:0]  hrs_snap_reg;

    // ------------------------------------------------------------------
    // Digit conversion of the snapshot
    // ------------------------------------------------------------------
    logic [4:0] hrs_show;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       is_pm;

    always_comb begin
        hrs_show = hrs_snap_reg;
        is_pm    = (hrs_snap_reg >= 5'd12);
`ifdef TWELVE_HOUR_EN
        if (hrs_snap_reg == 5'd0) begin
            hrs_show = 5'd12;
        end else if (hrs_snap_reg > 5'd12) begin
            hrs_show = hrs_snap_reg - 5'd12;
        end
`endif
        h1 = 4'(hrs_show / 5'd10);
        h0 = 4'(hrs_show % 5'd10);
        m1 = 4'(min_snap_reg / 6'd10);
        m0 = 4'(min_snap_reg % 6'd10);
        s1 = 4'(sec_snap_reg / 6'd10);
        s0 = 4'(sec_snap_reg % 6'd10);
    end

    logic [7:0] char_byte;

    always_comb begin
        char_byte = 8'h3A;
        case (idx_reg)
            4'd0:    char_byte = 8'h30 + {4'h0, h1};
            4'd1:    char_byte = 8'h30 + {4'h0, h0};
            4'd3:    char_byte = 8'h30 + {4'h0, m1};
            4'd4:    char_byte = 8'h30 + {4'h0, m0};
            4'd6:    char_byte = 8'h30 + {4'h0, s1};
            4'd7:    char_byte = 8'h30 + {4'h0, s0};
`ifdef TWELVE_HOUR_EN
            4'd8:    char_byte = 8'h20;
            4'd9:    char_byte = is_pm ? 8'h50 : 8'h41;
            4'd10:   char_byte = 8'h4D;
`endif
            default: char_byte = 8'h3A;
        endcase
    end

    // ------------------------------------------------------------------
    // What the nibble engine should send next, and the gap that follows it
    // ------------------------------------------------------------------
    logic [7:0]  cur_byte;
    logic [3:0]  cur_nib;
    logic        cur_rs;
    logic [31:0] cur_wait;
    logic        last_item;

    always_comb begin
        cur_byte = 8'h00;
        case (state_reg)
            CFG: begin
                case (idx_reg)
                    4'd0:    cur_byte = 8'h28;   // 4-bit, 2 lines, 5x8
                    4'd1:    cur_byte = 8'h06;   // entry mode: increment
                    4'd2:    cur_byte = 8'h0C;   // display on, cursor off
                    default: cur_byte = 8'h01;   // clear display
                endcase
            end
            ADDR:    cur_byte = 8'h80 | 8'(COL);
            CHARS:   cur_byte = char_byte;
            default: cur_byte = 8'h00;
        endcase

        // Init nibbles are sent alone; everything else is a byte split in two
        if (state_reg == INIT) begin
            cur_nib = (idx_reg == 4'd3) ? 4'h2 : 4'h3;
        end else begin
            cur_nib = low_nib_reg ? cur_byte[3:0] : cur_byte[7:4];
        end

        cur_rs = (state_reg == CHARS);

        if (state_reg == INIT) begin
            case (idx_reg)
                4'd0:    cur_wait = 32'(T_INIT1);
                4'd1:    cur_wait = 32'(T_INIT2);
                default: cur_wait = 32'(T_CMD);
            endcase
        end else if (!low_nib_reg) begin
            cur_wait = 32'(T_NIBBLE);
        end else if (state_reg == CFG && idx_reg == 4'd3) begin
            cur_wait = 32'(T_CMD + T_CLEAR);
        end else begin
            cur_wait = 32'(T_CMD);
        end

        case (state_reg)
            INIT:    last_item = (idx_reg == 4'd3);
            CFG:     last_item = (idx_reg == 4'd3);
            ADDR:    last_item = 1'b1;
            CHARS:   last_item = (idx_reg == 4'(NCHARS - 1));
            default: last_item = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= PWR_WAIT;
            phase_reg    <= PH_SETUP;
            idx_reg      <= 4'd0;
            low_nib_reg  <= 1'b0;
            cnt_reg      <= 32'd0;
            sec_snap_reg <= 6'd0;
            min_snap_reg <= 6'd0;
            hrs_snap_reg <= 5'd0;
            SF_D         <= 4'h0;
            LCD_E        <= 1'b0;
            LCD_RS       <= 1'b0;
            LCD_RW       <= 1'b0;
            SF_CE0       <= 1'b1;
            init_done    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            LCD_RW     <= 1'b0;
            SF_CE0     <= 1'b1;
            frame_done <= 1'b0;
            case (state_reg)
                PWR_WAIT: begin
                    if (cnt_reg == 32'(T_POWERUP - 1)) begin
                        state_reg   <= INIT;
                        phase_reg   <= PH_SETUP;
                        idx_reg     <= 4'd0;
                        low_nib_reg <= 1'b0;
                        cnt_reg     <= 32'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end

                SNAP: begin
                    sec_snap_reg <= sec_digits;
                    min_snap_reg <= min_digits;
                    hrs_snap_reg <= hrs_digits;
                    state_reg    <= ADDR;
                    phase_reg    <= PH_SETUP;
                    idx_reg      <= 4'd0;
                    low_nib_reg  <= 1'b0;
                    cnt_reg      <= 32'd0;
                end

                FRAME_END: begin
                    frame_done <= 1'b1;
                    state_reg  <= SNAP;
                end

                default: begin
                    // INIT, CFG, ADDR and CHARS all run the nibble engine
                    case (phase_reg)
                        PH_SETUP: begin
                            // cnt 0 loads the bus, cnt 1..2 are the setup hold
                            if (cnt_reg == 32'd0) begin
                                SF_D    <= cur_nib;
                                LCD_RS  <= cur_rs;
                                cnt_reg <= 32'd1;
                            end else if (cnt_reg == 32'd1) begin
                                cnt_reg <= 32'd2;
                            end else begin
                                LCD_E     <= 1'b1;
                                phase_reg <= PH_PULSE;
                                cnt_reg   <= 32'd0;
                            end
                        end

                        PH_PULSE: begin
                            if (cnt_reg == 32'(T_EPULSE - 1)) begin
                                LCD_E     <= 1'b0;
                                phase_reg <= PH_WAIT;
                                cnt_reg   <= 32'd0;
                            end else begin
                                cnt_reg <= cnt_reg + 32'd1;
                            end
                        end

                        default: begin
                            if (cnt_reg == cur_wait - 32'd1) begin
                                cnt_reg   <= 32'd0;
                                phase_reg <= PH_SETUP;
                                if (state_reg != INIT && !low_nib_reg) begin
                                    low_nib_reg <= 1'b1;
                                end else begin
                                    low_nib_reg <= 1'b0;
                                    if (!last_item) begin
                                        idx_reg <= idx_reg + 4'd1;
                                    end else begin
                                        idx_reg <= 4'd0;
                                        case (state_reg)
                                            INIT: state_reg <= CFG;
                                            CFG: begin
                                                init_done <= 1'b1;
                                                state_reg <= SNAP;
                                            end
                                            ADDR:    state_reg <= CHARS;
                                            default: state_reg <= FRAME_END;
                                        endcase
                                    end
                                end
                            end else begin
                                cnt_reg <= cnt_reg + 32'd1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_time_display.sv
module tb_lcd_time_display;

    localparam int P_POWERUP = 100;
    localparam int P_INIT1   = 50;
    localparam int P_INIT2   = 20;
    localparam int P_EPULSE  = 12;
    localparam int P_NIBBLE  = 10;
    localparam int P_CMD     = 40;
    localparam int P_CLEAR   = 60;
    localparam int BOUND     = 3000;

`ifdef TWELVE_HOUR_EN
    localparam int NCH = 11;
`else
    localparam int NCH = 8;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [5:0] sec = 6'd0;
    logic [5:0] min = 6'd0;
    logic [4:0] hrs = 5'd0;
    logic [3:0] SF_D;
    logic       LCD_E, LCD_RS, LCD_RW, SF_CE0, init_done, frame_done;

    lcd_time_display #(
        .T_POWERUP(P_POWERUP), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2),
        .T_EPULSE(P_EPULSE), .T_NIBBLE(P_NIBBLE), .T_CMD(P_CMD),
        .T_CLEAR(P_CLEAR), .COL(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .sec_digits(sec), .min_digits(min), .hrs_digits(hrs),
        .SF_D(SF_D), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .SF_CE0(SF_CE0), .init_done(init_done), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int viol = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- bus monitor: one record per LCD_E pulse -------------
    typedef struct {
        logic [3:0] d;
        logic       rs;
        int         width;
        int         setup;
        bit         chg;
        int         rise_cyc;
        int         fall_cyc;
    } nib_t;

    nib_t nq[$];
    int   fq[$];
    nib_t cur;
    logic prev_e = 1'b0;
    logic [3:0] last_d = 4'h0;
    logic last_rs = 1'b0;
    int   stable = 0;
    int   fd_run = 0;

    always @(negedge CLK) begin
        if (SF_CE0 !== 1'b1 || LCD_RW !== 1'b0) viol++;
        if (!RST_N) begin
            prev_e  = 1'b0;
            fd_run  = 0;
            stable  = 0;
            last_d  = SF_D;
            last_rs = LCD_RS;
        end else begin
            if (SF_D === last_d && LCD_RS === last_rs) stable++;
            else stable = 0;
            last_d  = SF_D;
            last_rs = LCD_RS;
            if (LCD_E && !prev_e) begin
                cur.d = SF_D; cur.rs = LCD_RS; cur.width = 1;
                cur.setup = stable; cur.chg = 1'b0; cur.rise_cyc = cyc;
            end else if (LCD_E && prev_e) begin
                cur.width++;
                if (SF_D !== cur.d || LCD_RS !== cur.rs) cur.chg = 1'b1;
            end else if (!LCD_E && prev_e) begin
                cur.fall_cyc = cyc;
                nq.push_back(cur);
            end
            prev_e = LCD_E;
            if (frame_done) fd_run++;
            else if (fd_run != 0) begin
                fq.push_back(fd_run);
                fd_run = 0;
            end
        end
    end

    // ---------------- helpers ---------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic get_nib(output nib_t r);
        int n = 0;
        while (nq.size() == 0 && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
        check("nibble_arrives", nq.size() != 0, 1);
        if (nq.size() != 0) r = nq.pop_front();
        else r = '{4'h0, 1'b0, 0, 0, 1'b0, 0, 0};
        check("e_width", r.width, P_EPULSE);
        check("setup_ge2", r.setup >= 2, 1);
        check("hold_in_pulse", r.chg, 0);
    endtask

    task automatic check_byte(input string tag, input logic [7:0] eb, input logic ers,
                              output nib_t lo);
        nib_t hi;
        get_nib(hi);
        get_nib(lo);
        $display("byte %s: %02h rs=%0d (expect %02h rs=%0d)", tag, {hi.d, lo.d}, hi.rs, eb, ers);
        check({tag, "_byte"}, {hi.d, lo.d}, eb);
        check({tag, "_rs_hi"}, hi.rs, ers);
        check({tag, "_rs_lo"}, lo.rs, ers);
        check({tag, "_nib_gap"}, (lo.rise_cyc - hi.fall_cyc) >= P_NIBBLE, 1);
    endtask

    task automatic check_init(input int rel);
        nib_t r, p;
        logic [3:0] exp_nib;
        int n;
        for (int i = 0; i < 4; i++) begin
            get_nib(r);
            exp_nib = (i == 3) ? 4'h2 : 4'h3;
            $display("init nibble %0d: %0h rs=%0d", i, r.d, r.rs);
            if (i == 0) check("pwr_wait", (r.rise_cyc - rel) >= P_POWERUP, 1);
            if (i == 1) check("init1_gap", (r.rise_cyc - p.fall_cyc) >= P_INIT1, 1);
            if (i == 2) check("init2_gap", (r.rise_cyc - p.fall_cyc) >= P_INIT2, 1);
            check("init_nib", r.d, exp_nib);
            check("init_rs", r.rs, 0);
            p = r;
        end
        check_byte("cfg28", 8'h28, 1'b0, r);
        check_byte("cfg06", 8'h06, 1'b0, r);
        check_byte("cfg0c", 8'h0C, 1'b0, r);
        check_byte("cfg01", 8'h01, 1'b0, r);
        check("init_done_early", init_done, 0);
        n = 0;
        while (!init_done && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
        check("init_done_rise", init_done, 1);
        check("clear_wait", (cyc - r.fall_cyc) >= (P_CMD + P_CLEAR), 1);
    endtask

    logic [4:0] mid_h, nxt_h;
    logic [5:0] mid_m, mid_s, nxt_m, nxt_s;

    task automatic read_frame(input logic [87:0] exp, input int mid_idx);
        nib_t r;
        logic [7:0] eb;
        int n;
        check_byte("addr", 8'h84, 1'b0, r);
        for (int i = 0; i < NCH; i++) begin
            if (i == mid_idx) begin
                n = 0;
                while (!LCD_E && n < BOUND) begin
                    @(negedge CLK);
                    n++;
                end
                check("mid_frame_e", LCD_E, 1);
                hrs = mid_h; min = mid_m; sec = mid_s;
            end
            eb = exp[8*(NCH-1-i) +: 8];
            check_byte($sformatf("char%0d", i), eb, 1'b1, r);
        end
        hrs = nxt_h; min = nxt_m; sec = nxt_s;
        n = 0;
        while (fq.size() == 0 && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
        check("frame_done_seen", fq.size() != 0, 1);
        if (fq.size() != 0) check("frame_done_width", fq.pop_front(), 1);
    endtask

    // ---------------- directed sequence -----------------------------------
    logic [87:0] e1, e2, e3, e4;
    int rel;
    int n;

    initial begin
`ifdef TWELVE_HOUR_EN
        e1 = "12:34:56 PM"; e2 = "11:59:59 PM"; e3 = "12:00:00 AM"; e4 = "01:07:09 PM";
`else
        e1 = "12:34:56";    e2 = "23:59:59";    e3 = "00:00:00";    e4 = "31:07:63";
`endif
        hrs = 5'd12; min = 6'd34; sec = 6'd56;
        repeat (3) @(negedge CLK);
        check("rst_sf_d", SF_D, 4'h0);
        check("rst_lcd_e", LCD_E, 0);
        check("rst_lcd_rs", LCD_RS, 0);
        check("rst_lcd_rw", LCD_RW, 0);
        check("rst_sf_ce0", SF_CE0, 1);
        check("rst_init_done", init_done, 0);
        check("rst_frame_done", frame_done, 0);

        RST_N = 1'b1;
        rel = cyc;
        check_init(rel);

        // frame 1: 12:34:56, then 23:59:59 is ready before the next snapshot
        nxt_h = 5'd23; nxt_m = 6'd59; nxt_s = 6'd59;
        read_frame(e1, -1);
        // frame 2: inputs flip to 00:00:00 during the 4th character
        mid_h = 5'd0; mid_m = 6'd0; mid_s = 6'd0;
        nxt_h = 5'd0; nxt_m = 6'd0; nxt_s = 6'd0;
        read_frame(e2, 3);
        // frame 3: 00:00:00, then an out-of-range / afternoon value
`ifdef TWELVE_HOUR_EN
        nxt_h = 5'd13; nxt_m = 6'd7; nxt_s = 6'd9;
`else
        nxt_h = 5'd31; nxt_m = 6'd7; nxt_s = 6'd63;
`endif
        read_frame(e3, -1);
        read_frame(e4, -1);

        // asynchronous reset while LCD_E is high
        n = 0;
        while (!LCD_E && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
        check("pre_reset_e", LCD_E, 1);
        #2 RST_N = 1'b0;
        #1;
        check("arst_sf_d", SF_D, 4'h0);
        check("arst_lcd_e", LCD_E, 0);
        check("arst_lcd_rs", LCD_RS, 0);
        check("arst_sf_ce0", SF_CE0, 1);
        check("arst_init_done", init_done, 0);
        check("arst_frame_done", frame_done, 0);
        repeat (4) @(negedge CLK);
        nq.delete();
        fq.delete();
        RST_N = 1'b1;
        rel = cyc;
        check_init(rel);
        read_frame(e4, -1);

        check("ce0_rw_constant", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
